count_seek_ctrl: RTL and testbench

Command-side controller for the 5-bit up/down counter's Load/Up/Down interface. Given a target value, it drives the counter there either by single-step Up/Down pulses at a programmable rate or by one Load. It watches the counter's Counter/High/Low feedback to decide each step and to confirm arrival. It sits between the control logic that issues seek requests and the counter instance.

---
 rtl/count_seek_ctrl_pkg.sv | 19 +
 rtl/count_seek_ctrl_if.sv | 33 +++
 rtl/count_seek_ctrl.sv | 116 +++++++++++
 tb/tb_count_seek_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seek_ctrl_pkg.sv
// Shared constants for the count/seek controller: default width, mode codes
// and the legacy-compatible state encoding.
package count_seek_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 5;

    localparam logic MODE_STEP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t CMP       = 3'd1;
    localparam state_t STEP_WAIT = 3'd2;
    localparam state_t LD        = 3'd3;
    localparam state_t LD_WAIT   = 3'd4;
    localparam state_t CHK       = 3'd5;

endpackage

// File: rtl/count_seek_ctrl_if.sv
// Seek request side plus counter command/feedback side of the controller.
// The controller takes the master modport; its environment takes the slave modport.
interface count_seek_ctrl_if
    import count_seek_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             Start;
    logic             Abort;
    logic             Mode;
    logic [WIDTH-1:0] Target;
    logic [WIDTH-1:0] Counter;
    logic             High;
    logic             Low;
    logic             Up;
    logic             Down;
    logic             Load;
    logic [WIDTH-1:0] Load_Value;
    logic             Busy;
    logic             Done;
    logic             Error;

    modport master (
        input  Start, Abort, Mode, Target, Counter, High, Low,
        output Up, Down, Load, Load_Value, Busy, Done, Error
    );

    modport slave (
        output Start, Abort, Mode, Target, Counter, High, Low,
        input  Up, Down, Load, Load_Value, Busy, Done, Error
    );

endinterface

// File: rtl/count_seek_ctrl.sv
// Drives an external up/down counter to a requested value, either by paced
// single steps or by one Load, and confirms arrival from the counter feedback.
module count_seek_ctrl
    import count_seek_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int STEP_DIV = 1
) (
    input  logic              CLK,
    input  logic              RST,
    count_seek_ctrl_if.master bus
);

    localparam int                WAIT_W     = (STEP_DIV < 1) ? 1 : $clog2(STEP_DIV + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(STEP_DIV);
    localparam logic [WIDTH:0]    STEP_LIMIT = {1'b1, {WIDTH{1'b0}}};

    state_t            state;
    logic [WIDTH-1:0]  tgt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WIDTH:0]    step_cnt;
    logic              arrive;
    logic              fault;
    logic              step_up;
    logic              step_dn;

    assign bus.Load_Value = tgt;

    // Arrival is tested before the step limit, so a seek that lands on its
    // final allowed step still completes cleanly.
    always_comb begin
        arrive  = 1'b0;
        fault   = 1'b0;
        step_up = 1'b0;
        step_dn = 1'b0;
        case (state)
            CMP: begin
                if (bus.Counter == tgt)
                    arrive = 1'b1;
                else if (step_cnt == STEP_LIMIT)
                    fault = 1'b1;
                else if (bus.Counter < tgt) begin
                    if (bus.High) fault = 1'b1;
                    else          step_up = 1'b1;
                end else begin
                    if (bus.Low) fault = 1'b1;
                    else         step_dn = 1'b1;
                end
            end
            CHK: begin
                if (bus.Counter == tgt) arrive = 1'b1;
                else                    fault  = 1'b1;
            end
            default: ;
        endcase
    end

    // Pulses default low each cycle; Abort outranks every state and leaves Error alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tgt       <= '0;
            wait_cnt  <= '0;
            step_cnt  <= '0;
            bus.Up    <= 1'b0;
            bus.Down  <= 1'b0;
            bus.Load  <= 1'b0;
            bus.Busy  <= 1'b0;
            bus.Done  <= 1'b0;
            bus.Error <= 1'b0;
        end else begin
            bus.Up   <= 1'b0;
            bus.Down <= 1'b0;
            bus.Load <= 1'b0;
            bus.Done <= 1'b0;
            if (bus.Abort) begin
                state    <= IDLE;
                bus.Busy <= 1'b0;
            end else if (arrive || fault) begin
                state    <= IDLE;
                bus.Busy <= 1'b0;
                bus.Done <= 1'b1;
                if (fault) bus.Error <= 1'b1;
            end else if (step_up || step_dn) begin
                bus.Up   <= step_up;
                bus.Down <= step_dn;
                wait_cnt <= WAIT_LOAD;
                step_cnt <= step_cnt + 1'b1;
                state    <= STEP_WAIT;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.Start) begin
                            tgt       <= bus.Target;
                            step_cnt  <= '0;
                            bus.Busy  <= 1'b1;
                            bus.Error <= 1'b0;
                            state     <= (bus.Mode == MODE_LOAD) ? LD : CMP;
                        end
                    end
                    STEP_WAIT: begin
                        wait_cnt <= wait_cnt - 1'b1;
                        if (wait_cnt == WAIT_W'(1)) state <= CMP;
                    end
                    LD: begin
                        bus.Load <= 1'b1;
                        state    <= LD_WAIT;
                    end
                    LD_WAIT: state <= CHK;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_seek_ctrl.sv
// Two controllers (STEP_DIV=1 and STEP_DIV=3) each driving a behavioural 5-bit
// up/down counter; expected output traces are built from the seek timing rules.
module tb_count_seek_ctrl;
    import count_seek_ctrl_pkg::*;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   start = '0;
    logic [1:0]   abort = '0;
    logic [1:0]   mode = '0;
    logic [1:0]   ext_load = '0;
    logic [W-1:0] target_a = '0, target_b = '0;
    logic [W-1:0] ext_val_a = '0, ext_val_b = '0;
    logic [W-1:0] cnt_a = '0, cnt_b = '0;
    logic         stub_en = 1'b0, stub_high = 1'b0, stub_low = 1'b0;
    logic [W-1:0] stub_val = '0;

    int passed = 0;
    int total = 0;
    int edge_cnt = 0;
    int ups[2], downs[2], loads[2], busy_n[2], dones[2], done_edge[2];
    int start_edge[2];
    int base_up, base_dn, base_ld, base_busy, base_done;
    logic [10:0] exp_a[$];
    logic [10:0] exp_b[$];

    count_seek_ctrl_if #(.WIDTH(W)) bus_a ();
    count_seek_ctrl_if #(.WIDTH(W)) bus_b ();

    count_seek_ctrl #(.WIDTH(W), .STEP_DIV(1)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
    count_seek_ctrl #(.WIDTH(W), .STEP_DIV(3)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

    assign bus_a.Start   = start[0];
    assign bus_a.Abort   = abort[0];
    assign bus_a.Mode    = mode[0];
    assign bus_a.Target  = target_a;
    assign bus_a.Counter = stub_en ? stub_val  : cnt_a;
    assign bus_a.High    = stub_en ? stub_high : (cnt_a == 5'd31);
    assign bus_a.Low     = stub_en ? stub_low  : (cnt_a == 5'd0);

    assign bus_b.Start   = start[1];
    assign bus_b.Abort   = abort[1];
    assign bus_b.Mode    = mode[1];
    assign bus_b.Target  = target_b;
    assign bus_b.Counter = cnt_b;
    assign bus_b.High    = (cnt_b == 5'd31);
    assign bus_b.Low     = (cnt_b == 5'd0);

    always #5 clk = ~clk;

    // Counters: controller Load first, then an external writer, then steps.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (bus_a.Load)       cnt_a <= bus_a.Load_Value;
        else if (ext_load[0]) cnt_a <= ext_val_a;
        else if (bus_a.Up)    cnt_a <= cnt_a + 1'b1;
        else if (bus_a.Down)  cnt_a <= cnt_a - 1'b1;
        if (bus_b.Load)       cnt_b <= bus_b.Load_Value;
        else if (ext_load[1]) cnt_b <= ext_val_b;
        else if (bus_b.Up)    cnt_b <= cnt_b + 1'b1;
        else if (bus_b.Down)  cnt_b <= cnt_b - 1'b1;
    end

    task automatic check_output(input string name, input int act, input int exp_v);
        total++;
        if (act == exp_v) passed++;
        else $display("[TB] FAIL %s at edge %0d: got 'h%0h, expected 'h%0h", name, edge_cnt, act, exp_v);
    endtask

    function automatic logic [10:0] mk(input logic up, input logic dn, input logic ld,
                                       input logic busy, input logic done, input logic err,
                                       input logic [W-1:0] lv);
        return {lv, up, dn, ld, busy, done, err};
    endfunction

    task automatic push_exp(input int lane, input logic [10:0] v);
        if (lane == 0) exp_a.push_back(v);
        else           exp_b.push_back(v);
    endtask

    // Step seek: pulses every s+1 cycles starting one cycle after Start, Done
    // after d*(s+1)+1 cycles; with abort_after>0 the seek is cut short after that many pulses.
    task automatic plan_step(input int lane, input int c, input int t, input int s, input int abort_after);
        int   d;
        int   n;
        logic up;
        d  = (t > c) ? t - c : c - t;
        up = (t > c);
        n  = (abort_after > 0) ? abort_after : d;
        push_exp(lane, mk(0, 0, 0, 1, 0, 0, '0));
        for (int i = 0; i < n; i++) begin
            push_exp(lane, mk(up, !up, 0, 1, 0, 0, '0));
            if (abort_after == 0 || i < n - 1)
                for (int w = 0; w < s; w++) push_exp(lane, mk(0, 0, 0, 1, 0, 0, '0));
        end
        if (abort_after > 0) begin
            push_exp(lane, mk(0, 0, 0, 0, 0, 0, '0));
            push_exp(lane, mk(0, 0, 0, 0, 0, 0, '0));
        end else begin
            push_exp(lane, mk(0, 0, 0, 0, 1, 0, '0));
            push_exp(lane, mk(0, 0, 0, 0, 0, 0, '0));
        end
    endtask

    task automatic plan_load(input int lane, input logic [W-1:0] t);
        push_exp(lane, mk(0, 0, 0, 1, 0, 0, '0));
        push_exp(lane, mk(0, 0, 1, 1, 0, 0, t));
        push_exp(lane, mk(0, 0, 0, 1, 0, 0, '0));
        push_exp(lane, mk(0, 0, 0, 0, 1, 0, '0));
        push_exp(lane, mk(0, 0, 0, 0, 0, 0, '0));
    endtask

    // Every cycle with a planned expectation is compared; pulse statistics feed the literal checks.
    always @(negedge clk) begin : compare
        logic [10:0] e;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            check_output("A {Up,Down,Load,Busy,Done,Error}",
                         {bus_a.Up, bus_a.Down, bus_a.Load, bus_a.Busy, bus_a.Done, bus_a.Error}, e[5:0]);
            if (e[3]) check_output("A Load_Value", bus_a.Load_Value, e[10:6]);
        end
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            check_output("B {Up,Down,Load,Busy,Done,Error}",
                         {bus_b.Up, bus_b.Down, bus_b.Load, bus_b.Busy, bus_b.Done, bus_b.Error}, e[5:0]);
            if (e[3]) check_output("B Load_Value", bus_b.Load_Value, e[10:6]);
        end
        ups[0] += int'(bus_a.Up);   downs[0] += int'(bus_a.Down);
        loads[0] += int'(bus_a.Load); busy_n[0] += int'(bus_a.Busy);
        ups[1] += int'(bus_b.Up);   downs[1] += int'(bus_b.Down);
        loads[1] += int'(bus_b.Load); busy_n[1] += int'(bus_b.Busy);
        if (bus_a.Done) begin dones[0] += 1; done_edge[0] = edge_cnt; end
        if (bus_b.Done) begin dones[1] += 1; done_edge[1] = edge_cnt; end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input int lane, input logic [W-1:0] v);
        ext_load[lane] = 1'b1;
        if (lane == 0) ext_val_a = v;
        else           ext_val_b = v;
        tick(1);
        ext_load[lane] = 1'b0;
    endtask

    task automatic snap(input int lane);
        base_up   = ups[lane];
        base_dn   = downs[lane];
        base_ld   = loads[lane];
        base_busy = busy_n[lane];
        base_done = dones[lane];
    endtask

    task automatic apply_stimulus(input int lane, input logic [W-1:0] t, input logic m);
        start[lane] = 1'b1;
        mode[lane]  = m;
        if (lane == 0) target_a = t;
        else           target_b = t;
        tick(1);
        start[lane]      = 1'b0;
        start_edge[lane] = edge_cnt;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        tick(3);
        push_exp(0, mk(0, 0, 0, 0, 0, 0, '0));
        push_exp(1, mk(0, 0, 0, 0, 0, 0, '0));
        check_output("reset Load_Value", bus_a.Load_Value, 0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // 3 -> 7 by single steps, one idle cycle between pulses
        preload(0, 5'd3);
        snap(0);
        apply_stimulus(0, 5'd7, MODE_STEP);
        plan_step(0, 3, 7, 1, 0);
        tick(12);
        check_output("s1 Up pulses", ups[0] - base_up, 4);
        check_output("s1 Done edge offset", done_edge[0] - start_edge[0], 9);
        check_output("s1 Counter", cnt_a, 7);

        // 20 -> 17 with three idle cycles between pulses
        preload(1, 5'd20);
        snap(1);
        apply_stimulus(1, 5'd17, MODE_STEP);
        plan_step(1, 20, 17, 3, 0);
        tick(16);
        check_output("s2 Down pulses", downs[1] - base_dn, 3);
        check_output("s2 Done edge offset", done_edge[1] - start_edge[1], 13);
        check_output("s2 Busy cycles", busy_n[1] - base_busy, 13);
        check_output("s2 Counter", cnt_b, 17);

        // 9 -> 25 with a single Load
        preload(0, 5'd9);
        snap(0);
        apply_stimulus(0, 5'd25, MODE_LOAD);
        plan_load(0, 5'd25);
        tick(6);
        check_output("s3 Load pulses", loads[0] - base_ld, 1);
        check_output("s3 step pulses", (ups[0] - base_up) + (downs[0] - base_dn), 0);
        check_output("s3 Done edge offset", done_edge[0] - start_edge[0], 3);
        check_output("s3 Counter", cnt_a, 25);

        // 0 -> 10 aborted after the second Up, then restarted from 2
        preload(0, 5'd0);
        snap(0);
        apply_stimulus(0, 5'd10, MODE_STEP);
        plan_step(0, 0, 10, 1, 2);
        tick(3);
        abort[0] = 1'b1;
        tick(1);
        abort[0] = 1'b0;
        tick(3);
        check_output("s4 Counter after abort", cnt_a, 2);
        check_output("s4 Done pulses after abort", dones[0] - base_done, 0);
        check_output("s4 Error after abort", bus_a.Error, 0);
        snap(0);
        apply_stimulus(0, 5'd10, MODE_STEP);
        plan_step(0, 2, 10, 1, 0);
        tick(20);
        check_output("s4 Up pulses on restart", ups[0] - base_up, 8);
        check_output("s4 Counter after restart", cnt_a, 10);

        // 30 -> 31 while an external writer loads 31 in the same cycle as the Up
        preload(0, 5'd30);
        apply_stimulus(0, 5'd31, MODE_STEP);
        plan_step(0, 30, 31, 1, 0);
        tick(1);
        ext_load[0] = 1'b1;
        ext_val_a   = 5'd31;
        tick(1);
        ext_load[0] = 1'b0;
        tick(4);
        check_output("s5 Counter", cnt_a, 31);
        check_output("s5 Done edge offset", done_edge[0] - start_edge[0], 3);

        // Stubbed feedback: Counter=31 yet Low=1 while seeking down to 0
        stub_val  = 5'd31;
        stub_high = 1'b0;
        stub_low  = 1'b1;
        stub_en   = 1'b1;
        snap(0);
        apply_stimulus(0, 5'd0, MODE_STEP);
        push_exp(0, mk(0, 0, 0, 1, 0, 0, '0));
        push_exp(0, mk(0, 0, 0, 0, 1, 1, '0));
        push_exp(0, mk(0, 0, 0, 0, 0, 1, '0));
        push_exp(0, mk(0, 0, 0, 0, 0, 1, '0));
        tick(4);
        stub_en = 1'b0;
        check_output("s6 Error sticky", bus_a.Error, 1);
        check_output("s6 Done pulses", dones[0] - base_done, 1);
        apply_stimulus(0, 5'd31, MODE_STEP);
        plan_step(0, 31, 31, 1, 0);
        tick(3);
        check_output("s6 Error cleared by Start", bus_a.Error, 0);

        // Start repeated while busy is ignored; RST mid-seek idles everything
        preload(0, 5'd5);
        snap(0);
        apply_stimulus(0, 5'd9, MODE_STEP);
        for (int i = 0; i < 5; i++) push_exp(0, mk(i % 2 == 1, 0, 0, 1, 0, 0, '0));
        push_exp(0, mk(0, 0, 0, 0, 0, 0, '0));
        push_exp(0, mk(0, 0, 0, 0, 0, 0, '0));
        tick(2);
        start[0] = 1'b1;
        target_a = 5'd0;
        mode[0]  = MODE_LOAD;
        tick(1);
        start[0] = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        check_output("s7 Counter after reset", cnt_a, 7);
        check_output("s7 Load pulses", loads[0] - base_ld, 0);
        check_output("s7 Done pulses", dones[0] - base_done, 0);
        apply_stimulus(0, 5'd9, MODE_STEP);
        plan_step(0, 7, 9, 1, 0);
        tick(7);
        check_output("s7 Counter after new seek", cnt_a, 9);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
